// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback queue entry type.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of writeback entries; exposes its storage, per-slot valid
// mask and head pointer so the top level can search pending writes.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                pushEntry,
    input  logic                     pop,
    output wb_entry_t                headEntry,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output wb_entry_t                entries [DEPTH],
    output logic [DEPTH-1:0]         validMask,
    output logic [$clog2(DEPTH)-1:0] headPtr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr <= '0;
            tailPtr <= '0;
            cnt     <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + 1'b1;
            if (pop)  headPtr <= headPtr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[tailPtr] <= pushEntry;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : gValid
        logic [PTR_W-1:0] age;
        assign age          = PTR_W'(i) - headPtr;
        assign validMask[i] = ({1'b0, age} < cnt);
        assign entries[i]   = mem[i];
    end

    assign headEntry = mem[headPtr];
    assign empty     = (cnt == '0);
    assign full      = (cnt == CNT_W'(DEPTH));
    assign count     = cnt;

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback sequencer for the regfile write port: arbitrates load/ALU requests,
// queues them in order, retires one per clock and forwards pending data.
// Optional macro WB_ZERO_REG_EN hardwires register 31 to zero.
module regfile_wb_queue
    import regfile_pkg::wb_entry_t;
    import regfile_pkg::ZERO_REG;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   memValid,
    output logic                   memReady,
    input  logic [ADDR_W-1:0]      memAddr,
    input  logic [DATA_W-1:0]      memData,
    input  logic                   aluValid,
    output logic                   aluReady,
    input  logic [ADDR_W-1:0]      aluAddr,
    input  logic [DATA_W-1:0]      aluData,
    output logic                   write,
    output logic [ADDR_W-1:0]      wrAddr,
    output logic [DATA_W-1:0]      wrData,
    input  logic [ADDR_W-1:0]      fwdAddrA,
    input  logic [ADDR_W-1:0]      fwdAddrB,
    output logic                   fwdHitA,
    output logic                   fwdHitB,
    output logic [DATA_W-1:0]      fwdDataA,
    output logic [DATA_W-1:0]      fwdDataB,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             full;
    logic             empty;
    logic             memFire;
    logic             aluFire;
    logic             push;
    wb_entry_t        pushEntry;
    wb_entry_t        headEntry;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] validMask;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] idx;

    // Ready depends on full only; a same-cycle pop does not free a slot early.
    assign memReady = !full;
    assign aluReady = !full && !memValid;
    assign memFire  = memValid && memReady;
    assign aluFire  = aluValid && aluReady;

    assign pushEntry.addr = memFire ? memAddr : aluAddr;
    assign pushEntry.data = memFire ? memData : aluData;

`ifdef WB_ZERO_REG_EN
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    // Writes to the zero register still handshake but never occupy a slot.
    assign push = (memFire || aluFire) && (pushEntry.addr != ZERO_ADDR);
`else
    assign push = memFire || aluFire;
`endif

    wb_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pushEntry (pushEntry),
        .pop       (!empty),
        .headEntry (headEntry),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .entries   (entries),
        .validMask (validMask),
        .headPtr   (headPtr)
    );

    assign write  = !empty;
    assign wrAddr = empty ? '0 : headEntry.addr;
    assign wrData = empty ? '0 : headEntry.data;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwdHitA  = 1'b0;
        fwdHitB  = 1'b0;
        fwdDataA = '0;
        fwdDataB = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = headPtr + PTR_W'(k);
            if (validMask[idx] && entries[idx].addr == fwdAddrA) begin
                fwdHitA  = 1'b1;
                fwdDataA = entries[idx].data;
            end
            if (validMask[idx] && entries[idx].addr == fwdAddrB) begin
                fwdHitB  = 1'b1;
                fwdDataB = entries[idx].data;
            end
        end
`ifdef WB_ZERO_REG_EN
        if (rst_n && fwdAddrA == ZERO_ADDR) begin
            fwdHitA  = 1'b1;
            fwdDataA = '0;
        end
        if (rst_n && fwdAddrB == ZERO_ADDR) begin
            fwdHitB  = 1'b1;
            fwdDataB = '0;
        end
`endif
    end

endmodule
